// File: rtl/dmem_pkg.sv
// dmem shared types: FSM states, access-size codes, byte-count helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } dmem_state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  function automatic logic [3:0] size_bytes(
    input logic [1:0] size
  );
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// dmem byte-lane logic: store merge and zero-extended load extract.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [63:0] old_dw,
  input  logic [63:0] wdata,
  input  logic [2:0]  off,
  input  logic [1:0]  size,
  output logic [63:0] st_dw,
  output logic [63:0] ld_val
);

  logic [63:0] size_mask;
  logic [63:0] lane_mask;
  logic [63:0] shifted;
  logic [5:0]  sh;

  assign sh = {off, 3'b000};

  always_comb begin
    // shift by 64 yields 0, so a doubleword mask is all ones
    size_mask = ~(64'hFFFF_FFFF_FFFF_FFFF
                  << {size_bytes(size), 3'b000});
    lane_mask = size_mask << sh;
    shifted   = wdata << sh;
    st_dw     = (old_dw & ~lane_mask) | (shifted & lane_mask);
    ld_val    = (old_dw >> sh) & size_mask;
  end

endmodule

// File: rtl/dmem.sv
// dmem: wait-stated data-memory responder with valid/ready channels.
// Optional alignment/range faults under DMEM_FAULT_EN.
module dmem
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WAIT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_fault
);

  localparam int IW = $clog2(DEPTH);
  localparam bit NOWAIT = (WAIT == 0);
  localparam logic [3:0] CNT_INIT =
    NOWAIT ? 4'd0 : 4'(WAIT - 1);

  dmem_state_t state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;

  logic        lat_write;
  logic [1:0]  lat_size;
  logic [63:0] lat_addr;
  logic [63:0] lat_wdata;

  logic        accept;
  logic        do_access;
  logic        a_write;
  logic [1:0]  a_size;
  logic [63:0] a_addr;
  logic [63:0] a_wdata;
  logic        a_fault;

  logic [IW-1:0] idx;
  logic [63:0]   mem [DEPTH];
  logic [63:0]   old_dw;
  logic [63:0]   st_dw;
  logic [63:0]   ld_val;

  assign req_ready  = reset && (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign accept     = req_ready && req_valid;

  // zero-wait access happens on the accepting edge, so use live inputs
  always_comb begin
    a_write = lat_write;
    a_size  = lat_size;
    a_addr  = lat_addr;
    a_wdata = lat_wdata;
    if (state == ST_IDLE) begin
      a_write = req_write;
      a_size  = req_size;
      a_addr  = req_addr;
      a_wdata = req_wdata;
    end
  end

  assign idx    = a_addr[IW+2:3];
  assign old_dw = mem[idx];

`ifdef DMEM_FAULT_EN
  logic misalign;
  logic oor;

  always_comb begin
    misalign = 1'b0;
    unique case (1'b1)
      (a_size == SZ_H): misalign = a_addr[0];
      (a_size == SZ_W): misalign = |a_addr[1:0];
      (a_size == SZ_D): misalign = |a_addr[2:0];
      default:          misalign = 1'b0;
    endcase
  end

  assign oor     = |(a_addr >> (IW + 3));
  assign a_fault = misalign | oor;
`else
  logic unused_addr;

  assign unused_addr = ^a_addr[63:IW+3];
  assign a_fault     = 1'b0;
`endif

  dmem_lane u_lane (
    .old_dw (old_dw),
    .wdata  (a_wdata),
    .off    (a_addr[2:0]),
    .size   (a_size),
    .st_dw  (st_dw),
    .ld_val (ld_val)
  );

  assign do_access = (accept && NOWAIT)
                  || (state == ST_WAIT && cnt == 4'd0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (NOWAIT) begin
            state_nxt = ST_RESP;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) state_nxt = ST_RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      ST_RESP: begin
        if (resp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      lat_write  <= 1'b0;
      lat_size   <= 2'b00;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        lat_write <= req_write;
        lat_size  <= req_size;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      if (do_access) begin
        resp_rdata <= (a_write || a_fault) ? '0 : ld_val;
        resp_fault <= a_fault;
      end
    end
  end

  // array is deliberately not reset
  always_ff @(posedge clk) begin
    if (do_access && a_write && !a_fault) begin
      mem[idx] <= st_dw;
    end
  end

endmodule

// File: tb/tb_dmem.sv
// tb_dmem: directed vectors, queue scoreboard with decoupled monitor.
module tb_dmem;
  import dmem_pkg::*;

  localparam int WT = 2;
  localparam int DP = 256;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [63:0] resp_rdata;
  logic        resp_fault;

  logic        r0_req_valid = 1'b0;
  logic        r0_req_ready;
  logic        r0_req_write = 1'b0;
  logic [1:0]  r0_req_size = 2'b11;
  logic [63:0] r0_req_addr = 64'h40;
  logic [63:0] r0_req_wdata = 64'h5A5A;
  logic        r0_resp_valid;
  logic        r0_resp_ready = 1'b1;
  logic [63:0] r0_resp_rdata;
  logic        r0_resp_fault;

  dmem #(.DEPTH(DP), .WAIT(WT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault)
  );

  dmem #(.DEPTH(DP), .WAIT(0)) u0 (
    .clk(clk), .reset(reset),
    .req_valid(r0_req_valid), .req_ready(r0_req_ready),
    .req_write(r0_req_write), .req_size(r0_req_size),
    .req_addr(r0_req_addr), .req_wdata(r0_req_wdata),
    .resp_valid(r0_resp_valid), .resp_ready(r0_resp_ready),
    .resp_rdata(r0_resp_rdata), .resp_fault(r0_resp_fault)
  );

  typedef struct {
    logic [63:0] d;
    logic        f;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   errs = 0;
  int   checks = 0;
  bit   pv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // monitor: compares every presented response against the queue head
  always @(negedge clk) begin
    if (reset && resp_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_resp: got valid=1 want 0");
      end else begin
        if (!pv) chk("latency", 64'(cyc), 64'(sbq[0].acc + WT + 1));
        chk("rdata", resp_rdata, sbq[0].d);
        chk("fault", 64'(resp_fault), 64'(sbq[0].f));
        if (!resp_ready) chk("req_ready_stall", 64'(req_ready), 64'd0);
        if (resp_ready) void'(sbq.pop_front());
      end
    end
    pv = reset && resp_valid && !resp_ready;
  end

  task automatic issue(input logic w, input logic [1:0] sz,
                       input logic [63:0] a, input logic [63:0] wd,
                       input logic [63:0] ed, input logic ef,
                       input bit push);
    exp_t e;
    bit done;
    done = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_write = w;
    req_size  = sz;
    req_addr  = a;
    req_wdata = wd;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin
        done = 1'b1;
        if (push) begin
          e.d = ed; e.f = ef; e.acc = cyc;
          sbq.push_back(e);
        end
      end
    end
    if (!done) begin
      checks++;
      errs++;
      $display("FAIL accept_timeout: got ready=0 want 1");
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = ~w;
    req_addr  = 64'hFFFF_FFFF_FFFF_FFF8;
    req_wdata = 64'h7777_7777_7777_7777;
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk); #1;
      if (sbq.size() == 0) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errs++;
      $display("FAIL resp_timeout: got pending=%0d want 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic op(input logic w, input logic [1:0] sz,
                    input logic [63:0] a, input logic [63:0] wd,
                    input logic [63:0] ed, input logic ef);
    issue(w, sz, a, wd, ed, ef, 1'b1);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int accs[$];
    bit got;
    logic [63:0] mis_w, mis_d, wrap_f, wrap_d;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    chk("rst_fault", 64'(resp_fault), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", 64'(req_ready), 64'd1);

    op(1, SZ_D, 64'h10, 64'hDEADBEEF_CAFEF00D, 64'd0, 0);
    op(0, SZ_D, 64'h10, 64'd0, 64'hDEADBEEF_CAFEF00D, 0);

    op(1, SZ_D, 64'h20, 64'd0, 64'd0, 0);
    op(1, SZ_B, 64'h23, 64'h1122_3344_5566_77AB, 64'd0, 0);
    op(0, SZ_D, 64'h20, 64'd0, 64'h00000000_AB000000, 0);
    op(0, SZ_H, 64'h22, 64'd0, 64'hAB00, 0);
    op(1, SZ_W, 64'h24, 64'hFFFF_FFFF_1122_3344, 64'd0, 0);
    op(0, SZ_D, 64'h20, 64'd0, 64'h11223344_AB000000, 0);
    op(0, SZ_W, 64'h24, 64'd0, 64'h11223344, 0);

`ifdef DMEM_FAULT_EN
    op(0, SZ_W, 64'h22, 64'd0, 64'd0, 1);
    op(0, SZ_D, 64'h26, 64'd0, 64'd0, 1);
    wrap_f = 64'd1;
    wrap_d = 64'h0F0F_0F0F_0F0F_0F0F;
`else
    op(0, SZ_W, 64'h22, 64'd0, 64'h3344AB00, 0);
    op(0, SZ_D, 64'h26, 64'd0, 64'h1122, 0);
    wrap_f = 64'd0;
    wrap_d = 64'h0000_0000_0000_BBBB;
`endif
    op(1, SZ_D, 64'h0, 64'h0F0F_0F0F_0F0F_0F0F, 64'd0, 0);
    op(1, SZ_D, 64'h800, 64'hBBBB, 64'd0, wrap_f[0]);
    op(0, SZ_D, 64'h0, 64'd0, wrap_d, 0);

    resp_ready = 1'b0;
    issue(0, SZ_D, 64'h10, 64'd0, 64'hDEADBEEF_CAFEF00D, 0, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (resp_valid) got = 1'b1;
    end
    chk("bp_valid_seen", 64'(got), 64'd1);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    resp_ready = 1'b1;
    wait_done();
    @(negedge clk);
    chk("bp_back_idle", 64'(req_ready), 64'd1);

    op(1, SZ_D, 64'h8, 64'h0123_4567_89AB_CDEF, 64'd0, 0);
    issue(1, SZ_D, 64'h8, 64'h1234, 64'd0, 0, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < WT + 3; i++) begin
      @(negedge clk);
      chk("abort_no_resp", 64'(resp_valid), 64'd0);
    end
    op(0, SZ_D, 64'h8, 64'd0, 64'h0123_4567_89AB_CDEF, 0);

    @(posedge clk); #1;
    r0_req_write = 1'b1;
    r0_req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (r0_resp_valid && accs.size() > 0)
        chk("w0_latency", 64'(cyc), 64'(accs[accs.size()-1] + 1));
      if (r0_req_ready) accs.push_back(cyc);
    end
    @(posedge clk); #1;
    r0_req_valid = 1'b0;
    chk("w0_accepts", 64'(accs.size()), 64'd4);
    for (int i = 1; i < accs.size(); i++)
      chk("w0_spacing", 64'(accs[i] - accs[i-1]), 64'd2);
    repeat (2) @(posedge clk); #1;
    r0_req_write = 1'b0;
    r0_req_valid = 1'b1;
    @(negedge clk);
    chk("w0_ld_ready", 64'(r0_req_ready), 64'd1);
    @(posedge clk); #1;
    r0_req_valid = 1'b0;
    @(negedge clk);
    chk("w0_ld_valid", 64'(r0_resp_valid), 64'd1);
    chk("w0_ld_rdata", r0_resp_rdata, 64'h5A5A);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
